// File: rtl/addr_bus_responder_pkg.sv
// Shared definitions for the address-bus responder: bus widths matching the
// address register, wait-counter width and the responder state encoding.
package addr_bus_responder_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/addr_bus_responder_wait_counter.sv
// Loadable 4-bit down-counter that times the responder's wait states.
// It saturates at zero, which is also what the zero flag reports.
module addr_bus_responder_wait_counter
  import addr_bus_responder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/addr_bus_responder.sv
// Memory-mapped byte responder: window decode, programmable wait states, one
// read/write per request. Define ADDR_RESP_BURST_EN to allow burst continuation.
//
// state  | meaning
// IDLE   | sampling requests; conflict pulses err
// WAIT   | burning WAIT_STATES cycles
// ACCESS | one RAM write, or RAM read into data_out
// DONE   | ready pulse (data_oe on reads); IDLE or next burst beat
module addr_bus_responder
  import addr_bus_responder_pkg::*;
#(
  parameter int                WIDTH       = ADDR_W,
  parameter int                DATA_WIDTH  = DATA_W,
  parameter logic [WIDTH-1:0]  BASE        = 16'h8000,
  parameter int                DEPTH       = 256,
  parameter int                WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic                  burst,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_oe,
  output logic                  ready,
  output logic                  err,
  output logic                  busy
);

  localparam int              OFFW  = $clog2(DEPTH);
  localparam logic [WIDTH:0]  LIMIT = (WIDTH+1)'({1'b0, BASE} + DEPTH);

  state_e                state_q;
  logic [OFFW-1:0]       off_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  is_wr_q;
  logic                  ready_q;
  logic                  err_q;
  logic                  oe_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  hit;
  logic                  one_req;
  logic                  both_req;
  logic [OFFW-1:0]       offset;
  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt;
  logic                  cnt_zero;
  logic                  wait_last;
  logic                  burst_go;

  // Compare one bit wider so a window ending at the top of the address map still works.
  assign hit      = ({1'b0, addr_in} >= {1'b0, BASE}) && ({1'b0, addr_in} < LIMIT);
  assign offset   = OFFW'(addr_in - BASE);
  assign one_req  = rd_req ^ wr_req;
  assign both_req = rd_req & wr_req;
  assign cnt_load = (state_q == ST_IDLE) && hit && one_req;

  addr_bus_responder_wait_counter u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(WAIT_STATES)),
    .dec_i      (state_q == ST_WAIT),
    .count_o    (cnt),
    .zero_o     (cnt_zero)
  );

  assign wait_last = cnt_zero || (cnt == CNT_W'(1));

`ifdef ADDR_RESP_BURST_EN
  assign burst_go = burst && (is_wr_q ? (wr_req && !rd_req) : (rd_req && !wr_req));
`else
  logic burst_unused;
  assign burst_unused = burst;
  assign burst_go     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      off_q      <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hit && one_req) begin
            off_q   <= offset;
            wdata_q <= data_in;
            is_wr_q <= wr_req;
            state_q <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
          end else if (hit && both_req) begin
            err_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_last) begin
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          state_q <= ST_DONE;
          ready_q <= 1'b1;
          oe_q    <= !is_wr_q;
          if (!is_wr_q) begin
            data_out_q <= mem[off_q];
          end
        end
        ST_DONE: begin
          if (burst_go) begin
            off_q   <= off_q + 1'b1;
            state_q <= ST_ACCESS;
            if (is_wr_q) begin
              wdata_q <= data_in;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Array is deliberately outside reset; a reset during ACCESS must still suppress the write.
  always_ff @(posedge clk) begin
    if (reset && (state_q == ST_ACCESS) && is_wr_q) begin
      mem[off_q] <= wdata_q;
    end
  end

  assign data_out = data_out_q;
  assign data_oe  = oe_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_addr_bus_responder.sv
// Self-checking bench for addr_bus_responder: a WAIT_STATES=2 instance and a
// WAIT_STATES=0 instance checked against a byte-array reference model.
module tb_addr_bus_responder;

  localparam int WS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] addr_in, addr0;
  logic [7:0]  data_in, data0;
  logic        rd_req, wr_req, rd0, wr0, burst;
  logic [7:0]  data_out, dout0;
  logic        data_oe, oe0, ready, ready0, err, err0, busy, busy0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] mem_m  [256];
  logic [7:0] mem0_m [256];

  addr_bus_responder #(.WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in),
    .rd_req(rd_req), .wr_req(wr_req), .burst(burst),
    .data_out(data_out), .data_oe(data_oe), .ready(ready), .err(err), .busy(busy)
  );

  addr_bus_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .addr_in(addr0), .data_in(data0),
    .rd_req(rd0), .wr_req(wr0), .burst(1'b0),
    .data_out(dout0), .data_oe(oe0), .ready(ready0), .err(err0), .busy(busy0)
  );

  // Raises one request at the current phase (just after an edge) and watches for ready.
  task automatic do_txn(input bit use0, input logic [15:0] a, input logic [7:0] d,
                        input bit is_wr, input int budget,
                        output bit seen, output int edges, output logic [7:0] rdata,
                        output logic oe_rdy, output bit oe_stray, output bit busy_seen);
    seen = 0; edges = 0; rdata = '0; oe_rdy = 1'b0; oe_stray = 0; busy_seen = 0;
    if (use0) begin
      addr0 = a; data0 = d; rd0 = !is_wr; wr0 = is_wr;
    end else begin
      addr_in = a; data_in = d; rd_req = !is_wr; wr_req = is_wr;
    end
    for (int k = 1; k <= budget && !seen; k++) begin
      @(posedge clk); #1;
      if (use0 ? busy0 : busy) busy_seen = 1;
      if (use0 ? ready0 : ready) begin
        seen = 1; edges = k;
        rdata  = use0 ? dout0 : data_out;
        oe_rdy = use0 ? oe0 : data_oe;
      end else if (use0 ? oe0 : data_oe) begin
        oe_stray = 1;
      end
    end
    rd0 = 1'b0; wr0 = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    addr_in = '0; data_in = '0; rd_req = 0; wr_req = 0; burst = 0;
    addr0 = '0; data0 = '0; rd0 = 0; wr0 = 0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got=%b exp=0", ready); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%b exp=0", err); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (data_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe got=%b exp=0", data_oe); end
    tests_run++; if (data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_dout got=%h exp=00", data_out); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    bit seen, oe_stray, bs; int edges; logic [7:0] rd; logic oe;
    do_txn(0, 16'h8010, 8'hA5, 1, 12, seen, edges, rd, oe, oe_stray, bs);
    mem_m[8'h10] = 8'hA5;
    tests_run++; if (edges !== WS + 2) begin tests_failed++; $display("FAIL wr_latency got=%0d exp=%0d", edges, WS + 2); end
    tests_run++; if ((oe !== 1'b0) || oe_stray) begin tests_failed++; $display("FAIL wr_oe got=%b stray=%0d exp=0", oe, oe_stray); end
    do_txn(0, 16'h8010, 8'h00, 0, 12, seen, edges, rd, oe, oe_stray, bs);
    tests_run++; if (edges !== WS + 2) begin tests_failed++; $display("FAIL rd_latency got=%0d exp=%0d", edges, WS + 2); end
    tests_run++; if (rd !== 8'hA5) begin tests_failed++; $display("FAIL rd_data got=%h exp=a5", rd); end
    tests_run++; if ((oe !== 1'b1) || oe_stray) begin tests_failed++; $display("FAIL rd_oe got=%b stray=%0d exp=1", oe, oe_stray); end
    tests_run++; if ((data_out !== 8'hA5) || (data_oe !== 1'b0)) begin
      tests_failed++; $display("FAIL rd_hold got=%h/%b exp=a5/0", data_out, data_oe);
    end
  endtask

  task automatic test_reset_mid_wait;
    int pulses = 0;
    addr_in = 16'h8010; rd_req = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    reset = 1'b0; rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if ({ready, err, busy, data_oe} !== 4'b0000) begin
      tests_failed++; $display("FAIL abort_flags got=%b exp=0000", {ready, err, busy, data_oe});
    end
    tests_run++; if (data_out !== 8'h00) begin tests_failed++; $display("FAIL abort_dout got=%h exp=00", data_out); end
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL abort_ready got=%0d exp=0", pulses); end
  endtask

  task automatic test_miss;
    bit seen, oe_stray, bs; int edges; logic [7:0] rd; logic oe;
    logic [15:0] miss_addr [2];
    miss_addr[0] = 16'h7FFF; miss_addr[1] = 16'h8100;
    for (int i = 0; i < 2; i++) begin
      do_txn(0, miss_addr[i], 8'h00, 0, 8, seen, edges, rd, oe, oe_stray, bs);
      tests_run++; if (seen || bs) begin
        tests_failed++; $display("FAIL miss_%h ready=%0d busy=%0d exp=0/0", miss_addr[i], seen, bs);
      end
    end
  endtask

  task automatic test_conflict;
    bit seen, oe_stray, bs; int edges; logic [7:0] rd; logic oe;
    do_txn(0, 16'h8000, 8'h3C, 1, 12, seen, edges, rd, oe, oe_stray, bs);
    mem_m[8'h00] = 8'h3C;
    addr_in = 16'h8000; data_in = 8'hC3; rd_req = 1'b1; wr_req = 1'b1;
    @(posedge clk); #1;
    tests_run++; if ((err !== 1'b1) || (busy !== 1'b0)) begin
      tests_failed++; $display("FAIL conflict_err got=%b/%b exp=1/0", err, busy);
    end
    rd_req = 1'b0; wr_req = 1'b0;
    @(posedge clk); #1;
    tests_run++; if ((err !== 1'b0) || (ready !== 1'b0)) begin
      tests_failed++; $display("FAIL conflict_pulse got=%b/%b exp=0/0", err, ready);
    end
    do_txn(0, 16'h8000, 8'h00, 0, 12, seen, edges, rd, oe, oe_stray, bs);
    tests_run++; if (rd !== 8'h3C) begin tests_failed++; $display("FAIL conflict_noaccess got=%h exp=3c", rd); end
  endtask

  task automatic test_random;
    bit seen, oe_stray, bs, hit_m, is_wr; int edges, sel; logic [7:0] rd, d; logic oe;
    logic [15:0] a;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      do_txn(0, 16'h8000 + 16'(i), d, 1, 12, seen, edges, rd, oe, oe_stray, bs);
      mem_m[i] = d;
    end
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 16'h8000 + 16'($urandom_range(0, 255));
      else if (sel == 7) a = 16'($urandom_range(0, 32'h7FFF));
      else               a = 16'($urandom_range(32'h8100, 32'hFFFF));
      hit_m = (int'(a) >= 32'h8000) && (int'(a) < 32'h8000 + 256);
      is_wr = 1'($urandom);
      d = 8'($urandom);
      do_txn(0, a, d, is_wr, 12, seen, edges, rd, oe, oe_stray, bs);
      if (hit_m) begin
        tests_run++; if (edges !== WS + 2) begin
          tests_failed++; $display("FAIL rand_latency a=%h got=%0d exp=%0d", a, edges, WS + 2);
        end
        if (is_wr) begin
          mem_m[a - 16'h8000] = d;
          tests_run++; if ((oe !== 1'b0) || oe_stray) begin tests_failed++; $display("FAIL rand_wr_oe a=%h got=%b exp=0", a, oe); end
        end else begin
          tests_run++; if ((rd !== mem_m[a - 16'h8000]) || (oe !== 1'b1)) begin
            tests_failed++; $display("FAIL rand_rd a=%h got=%h/%b exp=%h/1", a, rd, oe, mem_m[a - 16'h8000]);
          end
        end
      end else begin
        tests_run++; if (seen || bs) begin tests_failed++; $display("FAIL rand_miss a=%h ready=%0d busy=%0d exp=0/0", a, seen, bs); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int k1 = 0, k2 = 0;
    logic [7:0] d1 = '0, d2 = '0;
    addr_in = 16'h8020; rd_req = 1'b1;
    for (int k = 1; k <= 30 && k2 == 0; k++) begin
      @(posedge clk); #1;
      if (ready) begin
        if (k1 == 0) begin k1 = k; d1 = data_out; end
        else begin k2 = k; d2 = data_out; end
      end
    end
    rd_req = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (k1 != WS + 2) begin tests_failed++; $display("FAIL b2b_first got=%0d exp=%0d", k1, WS + 2); end
    tests_run++; if (k2 - k1 != WS + 3) begin tests_failed++; $display("FAIL b2b_gap got=%0d exp=%0d", k2 - k1, WS + 3); end
    tests_run++; if ((d1 !== mem_m[8'h20]) || (d2 !== mem_m[8'h20])) begin
      tests_failed++; $display("FAIL b2b_data got=%h,%h exp=%h", d1, d2, mem_m[8'h20]);
    end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_ws0;
    bit seen, oe_stray, bs; int edges; logic [7:0] rd; logic oe;
    do_txn(1, 16'h80FF, 8'h5A, 1, 8, seen, edges, rd, oe, oe_stray, bs);
    mem0_m[8'hFF] = 8'h5A;
    tests_run++; if (edges !== 2) begin tests_failed++; $display("FAIL ws0_wr_latency got=%0d exp=2", edges); end
    do_txn(1, 16'h8000, 8'h96, 1, 8, seen, edges, rd, oe, oe_stray, bs);
    mem0_m[8'h00] = 8'h96;
    do_txn(1, 16'h80FF, 8'h00, 0, 8, seen, edges, rd, oe, oe_stray, bs);
    tests_run++; if (edges !== 2) begin tests_failed++; $display("FAIL ws0_rd_latency got=%0d exp=2", edges); end
    tests_run++; if ((rd !== mem0_m[8'hFF]) || (oe !== 1'b1)) begin
      tests_failed++; $display("FAIL ws0_rd_data got=%h/%b exp=%h/1", rd, oe, mem0_m[8'hFF]);
    end
    do_txn(1, 16'h8000, 8'h00, 0, 8, seen, edges, rd, oe, oe_stray, bs);
    tests_run++; if (rd !== mem0_m[8'h00]) begin tests_failed++; $display("FAIL ws0_rd_base got=%h exp=%h", rd, mem0_m[8'h00]); end
  endtask

`ifdef ADDR_RESP_BURST_EN
  task automatic test_burst;
    bit seen, oe_stray, bs; int edges; logic [7:0] rd; logic oe;
    logic [7:0] beat_d [3];
    int beat_k [3];
    int beats = 0;
    beat_d[0] = 8'h11; beat_d[1] = 8'h22; beat_d[2] = 8'h33;
    addr_in = 16'h80FE; data_in = beat_d[0]; wr_req = 1'b1; burst = 1'b1;
    for (int k = 1; k <= 30 && beats < 3; k++) begin
      @(posedge clk); #1;
      if (ready) begin
        beat_k[beats] = k;
        beats++;
        if (beats < 3) data_in = beat_d[beats];
        else begin wr_req = 1'b0; burst = 1'b0; end
      end
    end
    wr_req = 1'b0; burst = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (beats != 3) begin tests_failed++; $display("FAIL burst_beats got=%0d exp=3", beats); end
    for (int i = 0; i < 3 && i < beats; i++) begin
      tests_run++; if (beat_k[i] != WS + 2 + 2 * i) begin
        tests_failed++; $display("FAIL burst_beat%0d_edge got=%0d exp=%0d", i, beat_k[i], WS + 2 + 2 * i);
      end
    end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL burst_end_idle got=%b exp=0", busy); end
    mem_m[8'hFE] = beat_d[0]; mem_m[8'hFF] = beat_d[1]; mem_m[8'h00] = beat_d[2];
    for (int i = 0; i < 3; i++) begin
      do_txn(0, 16'h80FE + 16'(i), 8'h00, 0, 12, seen, edges, rd, oe, oe_stray, bs);
      tests_run++; if (rd !== mem_m[8'(8'hFE + i)]) begin
        tests_failed++; $display("FAIL burst_readback%0d got=%h exp=%h", i, rd, mem_m[8'(8'hFE + i)]);
      end
    end
    do_txn(0, 16'h8001, 8'h00, 0, 12, seen, edges, rd, oe, oe_stray, bs);
    tests_run++; if (rd !== mem_m[8'h01]) begin tests_failed++; $display("FAIL burst_neighbour got=%h exp=%h", rd, mem_m[8'h01]); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_reset_mid_wait();
    test_miss();
    test_conflict();
    test_random();
    test_back_to_back();
    test_ws0();
`ifdef ADDR_RESP_BURST_EN
    test_burst();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
